// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: halfword width,
// compressed-instruction detection and the fetch-state flag bundle.
package fetch_pkg;

  localparam int HW_W = 16;

  // Low two bits of a halfword; all ones marks a 32-bit instruction.
  localparam logic [1:0] RVC_MASK = 2'b11;

  typedef struct packed {
    logic outstanding;  // a word request has been accepted and awaits its response
    logic discard;      // the outstanding response belongs to a flushed stream
    logic skip_low;     // first response after a redirect starts at its high half
  } fetch_flags_t;

  function automatic logic is_compressed(input logic [HW_W-1:0] hw);
    return (hw[1:0] & RVC_MASK) != RVC_MASK;
  endfunction

endpackage

// File: rtl/fetch_hw_ring.sv
// Halfword ring storage for the fetch queue: DEPTH x 16 bits, two write
// ports at wr_ptr and wr_ptr+1, two read ports at rd_ptr and rd_ptr+1.
// The +1 neighbours wrap modulo DEPTH so a pair may straddle the end.
module fetch_hw_ring
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic [PW-1:0]   wr_ptr,
  input  logic            wr_en0,
  input  logic [HW_W-1:0] wr_data0,
  input  logic            wr_en1,
  input  logic [HW_W-1:0] wr_data1,
  input  logic [PW-1:0]   rd_ptr,
  output logic [HW_W-1:0] rd_data0,
  output logic [HW_W-1:0] rd_data1
);

  logic [HW_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr1;
  logic [PW-1:0]   rd_ptr1;

  // Power-of-two depth: plain pointer overflow is the wrap.
  assign wr_ptr1 = wr_ptr + PW'(1);
  assign rd_ptr1 = rd_ptr + PW'(1);

  // Write up to two consecutive halfwords per cycle.
  // NOTE: the array has no reset; the parent's count decides which entries
  // are live, so stale contents are never presented as an instruction.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_ptr]  <= wr_data0;
    if (wr_en1) mem[wr_ptr1] <= wr_data1;
  end

  assign rd_data0 = mem[rd_ptr];
  assign rd_data1 = mem[rd_ptr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues one word request at a time, buffers the
// returned halfwords in a ring and hands whole instructions to decode.
// Build macro FETCH_RVC_EN enables 16-bit compressed instructions; without
// it every instruction is 32 bits and redirect targets are word aligned.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 8,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_comp
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] fetch_pc;
  fetch_flags_t      flags;

  logic [HW_W-1:0]   head_hw;
  logic [HW_W-1:0]   next_hw;
  logic              head_comp;
  logic [CW-1:0]     need;
  logic [CW-1:0]     free;
  logic [CW-1:0]     wr_n;
  logic [CW-1:0]     pop_n;
  logic              rsp_take;
  logic              rsp_drop;
  logic              req_fire;
  logic              pop_fire;
  logic              wr_en0;
  logic              wr_en1;
  logic [HW_W-1:0]   wr_data0;
  logic [ADDR_W-1:0] redirect_base;
  logic [ADDR_W-1:0] redirect_inst_pc;
  logic              redirect_skip;

  fetch_hw_ring #(.DEPTH(DEPTH)) u_ring (
    .clk      (clk),
    .wr_ptr   (tail),
    .wr_en0   (wr_en0),
    .wr_data0 (wr_data0),
    .wr_en1   (wr_en1),
    .wr_data1 (rsp_data[31:16]),
    .rd_ptr   (head),
    .rd_data0 (head_hw),
    .rd_data1 (next_hw)
  );

  assign redirect_base = redirect_pc & ~ADDR_W'(3);

`ifdef FETCH_RVC_EN
  assign head_comp        = is_compressed(head_hw);
  assign redirect_inst_pc = redirect_pc;
  assign redirect_skip    = redirect_pc[1];
`else
  assign head_comp        = 1'b0;
  assign redirect_inst_pc = redirect_base;
  assign redirect_skip    = 1'b0;
`endif

  // Head instruction size and decode handshake; a redirect overrides the pop.
  assign need       = head_comp ? CW'(1) : CW'(2);
  assign inst_valid = rst && (count >= need);
  assign pop_fire   = inst_valid && inst_ready && !redirect;
  assign pop_n      = pop_fire ? need : '0;

  // Response handling: live responses are written, flushed ones dropped.
  assign rsp_take = rsp_valid && flags.outstanding && !flags.discard && !redirect;
  assign rsp_drop = rsp_valid && flags.outstanding && flags.discard;
  assign wr_en0   = rsp_take;
  assign wr_en1   = rsp_take && !flags.skip_low;
  assign wr_data0 = flags.skip_low ? rsp_data[31:16] : rsp_data[15:0];
  assign wr_n     = rsp_take ? (flags.skip_low ? CW'(1) : CW'(2)) : '0;

  // One request in flight, and only with room for a whole word.
  assign free      = CW'(DEPTH) - count;
  assign req_valid = rst && !redirect && (!flags.outstanding || rsp_drop) && (free >= CW'(2));
  assign req_addr  = fetch_pc;
  assign req_fire  = req_valid && req_ready;

  // Present the head instruction to decode; zero when nothing is ready.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    inst_data = '0;
    inst_comp = 1'b0;
    if (inst_valid) begin
      inst_comp = head_comp;
      inst_data = head_comp ? {16'h0, head_hw} : {next_hw, head_hw};
    end
  end

  // Queue pointers, occupancy and the PC of the head halfword.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      inst_pc <= RESET_PC;
    end else if (redirect) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      inst_pc <= redirect_inst_pc;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(wr_n);
      count <= count + wr_n - pop_n;
      if (pop_fire) inst_pc <= inst_pc + (head_comp ? ADDR_W'(2) : ADDR_W'(4));
    end
  end

  // Fetch address and request-tracking flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      flags    <= '0;
    end else if (redirect) begin
      fetch_pc          <= redirect_base;
      // A response landing this very cycle is simply dropped; otherwise the
      // one still in flight must be thrown away when it arrives.
      flags.outstanding <= flags.outstanding && !rsp_valid;
      flags.discard     <= flags.outstanding && !rsp_valid;
      flags.skip_low    <= redirect_skip;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (req_fire) flags.outstanding <= 1'b1;
      else if (rsp_valid && flags.outstanding) flags.outstanding <= 1'b0;
      if (rsp_valid && flags.outstanding) flags.discard <= 1'b0;
      if (rsp_take) flags.skip_low <= 1'b0;
    end
  end

endmodule
